// File: rtl/rd_fifo_downconv.sv
// rd_fifo_downconv: 128-bit write / 16-bit read FIFO, lanes read out LSB first.
// Define RD_FIFO_OUTPUT_REG_EN for an extra rd_data register (2-cycle read latency).
module rd_fifo_downconv #(
   parameter int WR_DEPTH_WIDTH   = 6,
   parameter int ALMOST_FULL_NUM  = 60,
   parameter int ALMOST_EMPTY_NUM = 4
) (
   input  logic                      clk,
   input  logic                      tb_rst,
   input  logic                      wr_en,
   input  logic [127:0]              wr_data,
   output logic                      wr_full,
   output logic [WR_DEPTH_WIDTH:0]   wr_water_level,
   output logic                      almost_full,
   input  logic                      rd_en,
   output logic [15:0]               rd_data,
   output logic                      rd_empty,
   output logic [WR_DEPTH_WIDTH+3:0] rd_water_level,
   output logic                      almost_empty
);
   localparam int RD_DEPTH_WIDTH = WR_DEPTH_WIDTH + 3;
   localparam logic [WR_DEPTH_WIDTH:0] FULL_LVL = (WR_DEPTH_WIDTH+1)'(2**WR_DEPTH_WIDTH);
   localparam logic [WR_DEPTH_WIDTH:0] AF_LVL   = (WR_DEPTH_WIDTH+1)'(ALMOST_FULL_NUM);
   localparam logic [RD_DEPTH_WIDTH:0] AE_LVL   = (RD_DEPTH_WIDTH+1)'(ALMOST_EMPTY_NUM);

   logic [127:0]              mem_q [2**WR_DEPTH_WIDTH];
   logic [WR_DEPTH_WIDTH:0]   wr_ptr_q, wr_ptr_d;
   logic [RD_DEPTH_WIDTH:0]   rd_ptr_q, rd_ptr_d;
   logic [15:0]               rd_data_q, rd_data_d, lane;
   logic                      wr_acc, rd_acc;

   // a word slot is only released once its last lane has been read
   assign rd_water_level = {wr_ptr_q, 3'b000} - rd_ptr_q;
   assign wr_water_level = wr_ptr_q - rd_ptr_q[RD_DEPTH_WIDTH:3];
   assign wr_full        = wr_water_level == FULL_LVL;
   assign rd_empty       = rd_water_level == '0;
   assign almost_full    = wr_water_level >= AF_LVL;
   assign almost_empty   = rd_water_level <= AE_LVL;

   always_comb begin
      wr_acc    = wr_en && !wr_full;
      rd_acc    = rd_en && !rd_empty;
      wr_ptr_d  = wr_ptr_q + (WR_DEPTH_WIDTH+1)'(wr_acc);
      rd_ptr_d  = rd_ptr_q + (RD_DEPTH_WIDTH+1)'(rd_acc);
      lane      = mem_q[rd_ptr_q[RD_DEPTH_WIDTH-1:3]][{rd_ptr_q[2:0], 4'b0000} +: 16];
      rd_data_d = rd_acc ? lane : rd_data_q;
   end

   always_ff @(posedge clk) begin
      if (wr_acc) mem_q[wr_ptr_q[WR_DEPTH_WIDTH-1:0]] <= wr_data;
   end

   always_ff @(posedge clk or posedge tb_rst) begin
      if (tb_rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         rd_data_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         rd_data_q <= rd_data_d;
      end
   end

`ifdef RD_FIFO_OUTPUT_REG_EN
   logic [15:0] rd_out_q;
   always_ff @(posedge clk or posedge tb_rst) begin
      if (tb_rst) rd_out_q <= '0;
      else        rd_out_q <= rd_data_q;
   end
   assign rd_data = rd_out_q;
`else
   assign rd_data = rd_data_q;
`endif
endmodule

// File: tb/tb_rd_fifo_downconv.sv
// tb_rd_fifo_downconv: directed checks of the 128->16 read FIFO.
module tb_rd_fifo_downconv;
   logic         clk = 0;
   logic         tb_rst = 1;
   logic         wr_en = 0, rd_en = 0;
   logic [127:0] wr_data = '0;
   logic         wr_full, almost_full, rd_empty, almost_empty;
   logic [6:0]   wr_water_level;
   logic [9:0]   rd_water_level;
   logic [15:0]  rd_data;
   int           checks = 0, errors = 0;

   rd_fifo_downconv dut (
      .clk(clk), .tb_rst(tb_rst), .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
      .wr_water_level(wr_water_level), .almost_full(almost_full), .rd_en(rd_en),
      .rd_data(rd_data), .rd_empty(rd_empty), .rd_water_level(rd_water_level),
      .almost_empty(almost_empty)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] mkword(input int base);
      logic [127:0] w;
      for (int k = 0; k < 8; k++) w[16*k +: 16] = 16'(base + k);
      return w;
   endfunction

   task automatic step(input logic we, input logic [127:0] wd, input logic re);
      wr_en = we; wr_data = wd; rd_en = re;
      @(negedge clk);
      wr_en = 0; rd_en = 0;
   endtask

   task automatic rd_chk(input string tag, input logic [15:0] exp);
      step(0, '0, 1);
`ifdef RD_FIFO_OUTPUT_REG_EN
      step(0, '0, 0);
`endif
      check(tag, 64'(rd_data), 64'(exp));
   endtask

   task automatic reset_chk();
      check("rst_rd_data", 64'(rd_data), 0);
      check("rst_rd_empty", 64'(rd_empty), 1);
      check("rst_almost_empty", 64'(almost_empty), 1);
      check("rst_wr_full", 64'(wr_full), 0);
      check("rst_almost_full", 64'(almost_full), 0);
      check("rst_wr_level", 64'(wr_water_level), 0);
      check("rst_rd_level", 64'(rd_water_level), 0);
   endtask

   initial begin
      int exp_lane;
      logic acc1, acc2, v;
      repeat (2) @(posedge clk);
      reset_chk();
      @(negedge clk) tb_rst = 0;

      // single word, lanes 0..7
      step(1, mkword(0), 0);
      check("w1_rd_empty", 64'(rd_empty), 0);
      check("w1_rd_level", 64'(rd_water_level), 8);
      check("w1_wr_level", 64'(wr_water_level), 1);
      for (int k = 0; k < 8; k++) begin
         rd_chk("w1_lane", 16'(k));
         if (k == 2) check("ae_at5", 64'(almost_empty), 0);
         if (k == 3) check("ae_at4", 64'(almost_empty), 1);
      end
      check("w1_empty_after", 64'(rd_empty), 1);
      check("w1_wr_level_after", 64'(wr_water_level), 0);

      // reads on empty are ignored
      for (int i = 0; i < 10; i++) step(0, '0, 1);
      check("emp_rd_hold", 64'(rd_data), 64'h7);
      check("emp_rd_level", 64'(rd_water_level), 0);
      step(1, mkword(16'h10), 0);
      check("emp_wr_not_empty", 64'(rd_empty), 0);
      check("emp_rd_level8", 64'(rd_water_level), 8);
      for (int k = 0; k < 8; k++) rd_chk("emp_lane", 16'(16'h10 + k));

      // fill to full
      for (int i = 0; i < 64; i++) begin
         step(1, mkword(16'h100 + 8 * i), 0);
         if (i == 58) check("af_59", 64'(almost_full), 0);
         if (i == 59) check("af_60", 64'(almost_full), 1);
         if (i == 62) check("full_63", 64'(wr_full), 0);
      end
      check("full_64", 64'(wr_full), 1);
      check("full_wr_level", 64'(wr_water_level), 64);
      check("full_rd_level", 64'(rd_water_level), 512);
      step(1, mkword(16'hF000), 0);
      check("ovf_wr_level", 64'(wr_water_level), 64);
      check("ovf_rd_level", 64'(rd_water_level), 512);

      // word slot frees only after lane 7
      for (int k = 0; k < 7; k++) begin
         rd_chk("full_lane", 16'(16'h100 + k));
         check("full_hold", 64'(wr_full), 1);
      end
      rd_chk("full_lane7", 16'h107);
      check("full_release", 64'(wr_full), 0);
      check("rel_wr_level", 64'(wr_water_level), 63);
      check("rel_rd_level", 64'(rd_water_level), 504);

      // asynchronous reset with 20 words stored
      tb_rst = 1;
      @(negedge clk) tb_rst = 0;
      for (int i = 0; i < 20; i++) step(1, mkword(16'h200 + 8 * i), 0);
      check("r20_wr_level", 64'(wr_water_level), 20);
      rd_chk("r20_lane0", 16'h200);
      #2 tb_rst = 1;
      #1 reset_chk();
      @(negedge clk) tb_rst = 0;
      step(1, mkword(16'h300), 0);
      check("post_rst_rd_level", 64'(rd_water_level), 8);
      for (int k = 0; k < 8; k++) rd_chk("post_rst_lane", 16'(16'h300 + k));
      check("post_rst_empty", 64'(rd_empty), 1);

      // streaming: one word per 8 cycles, continuous read
      exp_lane = 0; acc1 = 0; acc2 = 0;
      for (int c = 0; c < 8 * 1000 + 20; c++) begin
         wr_en = (c % 8 == 0) && (c / 8 < 1000);
         wr_data = mkword(c);
         rd_en = 1;
         acc2 = acc1;
         acc1 = !rd_empty;
         @(negedge clk);
`ifdef RD_FIFO_OUTPUT_REG_EN
         v = acc2;
`else
         v = acc1;
`endif
         if (v) begin
            check("stream_lane", 64'(rd_data), 64'(16'(exp_lane)));
            exp_lane++;
         end
      end
      wr_en = 0; rd_en = 0;
      check("stream_count", 64'(exp_lane), 8000);
      check("stream_empty", 64'(rd_empty), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/rd_fifo_downconv.md
RD_FIFO_DOWNCONV -- requirements
Module: rd_fifo_downconv

Interface
REQ-001 SHALL have parameter WR_DEPTH_WIDTH, default 6: log2 of depth in 128-bit words (64 words).
REQ-002 SHALL have parameter ALMOST_FULL_NUM, default 60: almost_full threshold in 128-bit words.
REQ-003 SHALL have parameter ALMOST_EMPTY_NUM, default 4: almost_empty threshold in 16-bit lanes.
REQ-004 SHALL derive localparam RD_DEPTH_WIDTH = WR_DEPTH_WIDTH+3, giving 8 lanes per word.
REQ-005 clk  input  1  single clock for both ports; all logic on rising edge.
REQ-006 tb_rst  input  1  reset, asynchronous, active-high.
REQ-007 wr_en  input  1  write request.
REQ-008 wr_data  input  128  write word.
REQ-009 wr_full  output  1  no free word slot.
REQ-010 wr_water_level  output  WR_DEPTH_WIDTH+1  occupied words.
REQ-011 almost_full  output  1  wr_water_level >= ALMOST_FULL_NUM.
REQ-012 rd_en  input  1  read request.
REQ-013 rd_data  output  16  read lane.
REQ-014 rd_empty  output  1  no unread lane.
REQ-015 rd_water_level  output  RD_DEPTH_WIDTH+1  unread lanes.
REQ-016 almost_empty  output  1  rd_water_level <= ALMOST_EMPTY_NUM.

Function
REQ-017 Write SHALL be accepted iff wr_en && !wr_full; accepted word stored at wr_ptr[WR_DEPTH_WIDTH-1:0], wr_ptr += 1.
REQ-018 wr_en while wr_full SHALL be ignored: no storage, no pointer change, no error flag.
REQ-019 Read SHALL be accepted iff rd_en && !rd_empty; rd_ptr += 1 (lane granularity).
REQ-020 Lane order SHALL be LSB first: lane k of a word is wr_data[16k+15:16k], k = rd_ptr[2:0].
REQ-021 rd_data SHALL update exactly 1 cycle after an accepted read and hold until the next accepted read.
REQ-022 rd_en while rd_empty SHALL be ignored; rd_data holds, rd_ptr unchanged.
REQ-023 Pointers: wr_ptr WR_DEPTH_WIDTH+1 bits, rd_ptr RD_DEPTH_WIDTH+1 bits, both wrap modulo 2^width.
REQ-024 rd_water_level SHALL equal {wr_ptr,3'b000} - rd_ptr (modulo RD_DEPTH_WIDTH+1 bits).
REQ-025 wr_water_level SHALL equal wr_ptr - rd_ptr[RD_DEPTH_WIDTH:3]; a partially read word counts as occupied.
REQ-026 wr_full SHALL equal (wr_water_level == 2^WR_DEPTH_WIDTH); rd_empty SHALL equal (rd_water_level == 0).
REQ-027 All flags and levels SHALL be derived from registered pointers: they change in the cycle after the causing accept.
REQ-028 Simultaneous accepted read and write SHALL both take effect; a read in the full cycle does not allow a same-cycle write.
REQ-029 A write into an empty FIFO SHALL deassert rd_empty in the following cycle (1-cycle write-to-read latency).
REQ-030 Freeing a word slot SHALL occur when its lane 7 is read; wr_full deasserts the cycle after.

Reset
REQ-031 On tb_rst: wr_ptr=0, rd_ptr=0, rd_data=16'h0000, rd_empty=1, almost_empty=1, wr_full=0, almost_full=0, both levels 0.
REQ-032 Reset SHALL be honoured mid-transfer; stored RAM contents need not be cleared, but no data from before reset is ever readable.
REQ-033 First accept after tb_rst deasserts SHALL occur no earlier than the first rising clk edge with tb_rst low.

Configuration
REQ-034 Macro RD_FIFO_OUTPUT_REG_EN defined: extra output register; rd_data updates 2 cycles after accepted read; register reset to 0.
REQ-035 Macro undefined: rd_data latency 1 cycle per REQ-021; flag/level timing identical in both builds.

Verification
REQ-036 Reset, write 1 word 128'h0007_0006_0005_0004_0003_0002_0001_0000, read 8 -> rd_data 0000,0001..0007 in order, rd_empty=1 after 8th.
REQ-037 Write 64 words back-to-back -> wr_full=1 after 64th, 65th wr_en ignored, wr_water_level=64, rd_water_level=512, almost_full set at 60.
REQ-038 From full, read 7 lanes -> wr_full stays 1; 8th read -> wr_full=0 next cycle, wr_water_level=63.
REQ-039 rd_en held high on empty FIFO for 10 cycles -> rd_data unchanged, rd_ptr 0; write one word -> rd_empty low next cycle.
REQ-040 Continuous write 1 word per 8 cycles with continuous read, 1000 words -> lane stream contiguous incrementing, pointers wrap, no loss.
REQ-041 Assert tb_rst with 20 words stored -> all outputs per REQ-031 immediately; subsequent read returns only post-reset data.
